// File: rtl/pir_array_alarm.sv
// Per-channel windowed PIR averaging with threshold alarm, optional latching and trigger statistics.
// Latency: averages, alarm and statistics register on the window-closing tick edge; no backpressure, sensors sampled unconditionally.
module pir_array_alarm #(
  parameter int N_SENSORS    = 3,
  parameter int DATA_W       = 7,
  parameter int SAMPLE_DIV   = 4,
  parameter int LOG2_SAMPLES = 2,
  parameter int THRESHOLD    = 50,
  parameter int ALARM_CYCLES = 100,
  parameter int LATCH_MODE   = 0,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        turn,
  input  logic                        stop_alarm,
  input  logic                        clear_stats,
  input  logic [N_SENSORS*DATA_W-1:0] pir_sensor,
  output logic [N_SENSORS-1:0]        led,
  output logic                        buzzer,
  output logic [N_SENSORS*DATA_W-1:0] avg_bus,
  output logic                        avg_valid,
  output logic [DATA_W-1:0]           peak_value,
  output logic [3:0]                  peak_id,
  output logic [DATA_W-1:0]           last_value,
  output logic [3:0]                  last_id,
  output logic [CNT_W-1:0]            trigger_count,
  output logic [1:0]                  state
);
  localparam int ACC_W = DATA_W + LOG2_SAMPLES;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SMP_W = LOG2_SAMPLES + 1;
  localparam int ALM_W = $clog2(ALARM_CYCLES + 1);
  localparam int BUS_W = N_SENSORS * DATA_W;

  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLING = 2'd1, ALARM = 2'd2, COOLDOWN = 2'd3} state_t;
  state_t cur_state, nxt_state;

  logic [DIV_W-1:0]  div_cnt;
  logic [SMP_W-1:0]  smp_cnt;
  logic [ALM_W-1:0]  alarm_cnt;
  logic [ACC_W-1:0]  acc [N_SENSORS];

  logic              tick, win_end, trig, alarm_exit;
  logic [DATA_W-1:0] new_avg [N_SENSORS];
  logic [BUS_W-1:0]  new_bus;
  logic [N_SENSORS-1:0] mask;
  logic [4:0]        pop;
  logic [DATA_W-1:0] cand_val, hit_val;
  logic [3:0]        cand_id, hit_id;
  logic              cand_hit;

  logic [DATA_W-1:0] peak_nxt, last_nxt;
  logic [3:0]        peak_id_nxt, last_id_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W+4:0]  cnt_sum;

  assign state   = cur_state;
  assign tick    = (cur_state == SAMPLING) && turn && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign win_end = tick && (smp_cnt == SMP_W'((1 << LOG2_SAMPLES) - 1));
  assign trig    = win_end && (|mask);
  assign alarm_exit = stop_alarm || !turn ||
                      ((LATCH_MODE == 0) && (alarm_cnt == ALM_W'(ALARM_CYCLES - 1)));

  // The closing sample is folded in directly so the average is ready on the same edge.
  always_comb begin : avg_calc
    logic [ACC_W-1:0] sum;
    sum      = '0;
    new_bus  = '0;
    mask     = '0;
    pop      = '0;
    cand_val = '0;
    cand_id  = '0;
    cand_hit = 1'b0;
    hit_val  = '0;
    hit_id   = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      sum        = acc[i] + ACC_W'(pir_sensor[i*DATA_W +: DATA_W]);
      new_avg[i] = DATA_W'(sum >> LOG2_SAMPLES);
      new_bus[i*DATA_W +: DATA_W] = new_avg[i];
      mask[i]    = ($unsigned(32'(new_avg[i])) >= $unsigned(THRESHOLD));
      pop        = pop + 5'(mask[i]);
      if (mask[i] && (!cand_hit || new_avg[i] > cand_val)) begin
        cand_hit = 1'b1;
        cand_val = new_avg[i];
        cand_id  = 4'(i);
      end
      if (mask[i]) begin
        hit_val = new_avg[i];
        hit_id  = 4'(i);
      end
    end
  end

  // Clear takes effect first, so a coinciding trigger lands on zeroed statistics.
  always_comb begin
    peak_nxt    = clear_stats ? '0 : peak_value;
    peak_id_nxt = clear_stats ? '0 : peak_id;
    last_nxt    = clear_stats ? '0 : last_value;
    last_id_nxt = clear_stats ? '0 : last_id;
    cnt_nxt     = clear_stats ? '0 : trigger_count;
    cnt_sum     = '0;
    if (trig) begin
      cnt_sum = (CNT_W+5)'(cnt_nxt) + (CNT_W+5)'(pop);
      cnt_nxt = (|cnt_sum[CNT_W+4:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
      if (cand_val >= peak_nxt) begin
        peak_nxt    = cand_val;
        peak_id_nxt = cand_id;
      end
      last_nxt    = hit_val;
      last_id_nxt = hit_id;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:     if (turn) nxt_state = SAMPLING;
      SAMPLING: if (!turn) nxt_state = IDLE;
                else if (trig) nxt_state = ALARM;
      ALARM:    if (alarm_exit) nxt_state = COOLDOWN;
      COOLDOWN: nxt_state = turn ? SAMPLING : IDLE;
      default:  nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      smp_cnt   <= '0;
      alarm_cnt <= '0;
      led       <= '0;
      buzzer    <= 1'b0;
      avg_bus   <= '0;
      avg_valid <= 1'b0;
      for (int i = 0; i < N_SENSORS; i++) acc[i] <= '0;
    end else begin
      avg_valid <= 1'b0;
      case (cur_state)
        SAMPLING: begin
          if (!turn) begin
            div_cnt <= '0;
            smp_cnt <= '0;
            for (int i = 0; i < N_SENSORS; i++) acc[i] <= '0;
          end else if (tick) begin
            div_cnt <= '0;
            if (win_end) begin
              smp_cnt   <= '0;
              avg_bus   <= new_bus;
              avg_valid <= 1'b1;
              for (int i = 0; i < N_SENSORS; i++) acc[i] <= '0;
              if (trig) begin
                led       <= mask;
                buzzer    <= 1'b1;
                alarm_cnt <= '0;
              end
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
              for (int i = 0; i < N_SENSORS; i++)
                acc[i] <= acc[i] + ACC_W'(pir_sensor[i*DATA_W +: DATA_W]);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // Buzzer drops on the exit edge so an uninterrupted alarm lasts exactly ALARM_CYCLES.
        ALARM: begin
          if (alarm_exit) begin
            led       <= '0;
            buzzer    <= 1'b0;
            alarm_cnt <= '0;
          end else begin
            alarm_cnt <= alarm_cnt + 1'b1;
          end
        end
        default: begin
          led       <= '0;
          buzzer    <= 1'b0;
          alarm_cnt <= '0;
          div_cnt   <= '0;
          smp_cnt   <= '0;
          for (int i = 0; i < N_SENSORS; i++) acc[i] <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_value    <= '0;
      peak_id       <= '0;
      last_value    <= '0;
      last_id       <= '0;
      trigger_count <= '0;
    end else begin
      peak_value    <= peak_nxt;
      peak_id       <= peak_id_nxt;
      last_value    <= last_nxt;
      last_id       <= last_id_nxt;
      trigger_count <= cnt_nxt;
    end
  end

endmodule
